// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ID-stage FSM encoding and decoded-field payload.
package mips_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned OPC_W     = 6;
    localparam int unsigned FN_W      = 6;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
    localparam logic [FN_W-1:0]  FN_JR    = 6'h08;

    localparam logic [REG_IDX_W-1:0] REG_RA = 5'd31;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } id_state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic [XLEN-1:0]      imm;
        logic                 reg_write;
        logic                 mem_read;
        logic                 uses_rt;
    } dec_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decode: destination, immediate, write/read enables, rt usage.
import mips_pkg::*;

module id_decoder (
    input  logic [XLEN-1:0] i_instr,
    output dec_t            o_dec
);

    logic [OPC_W-1:0]     w_op;
    logic [FN_W-1:0]      w_funct;
    logic [REG_IDX_W-1:0] w_rt;
    logic [REG_IDX_W-1:0] w_rd;
    logic                 w_unused_rs;

    assign w_op        = i_instr[31:26];
    assign w_funct     = i_instr[5:0];
    assign w_rt        = i_instr[20:16];
    assign w_rd        = i_instr[15:11];
    assign w_unused_rs = ^i_instr[25:21];

    always_comb begin
        o_dec = '0;

        if (w_op == OP_RTYPE) begin
            o_dec.dst = w_rd;
        end else if (w_op == OP_JAL) begin
            o_dec.dst = REG_RA;
        end else begin
            o_dec.dst = w_rt;
        end

        // Logical immediates zero-extend; everything else sign-extends.
        if (w_op == OP_ANDI || w_op == OP_ORI || w_op == OP_XORI) begin
            o_dec.imm = {16'h0000, i_instr[15:0]};
        end else begin
            o_dec.imm = sext16(i_instr[15:0]);
        end

        o_dec.reg_write = ((w_op == OP_RTYPE) && (w_funct != FN_JR))
                        || (w_op[5:3] == 3'b001)
                        || (w_op == OP_LW)
                        || (w_op == OP_JAL);
        o_dec.mem_read  = (w_op == OP_LW);
        o_dec.uses_rt   = (w_op == OP_RTYPE) || (w_op == OP_SW)
                        || (w_op == OP_BEQ)  || (w_op == OP_BNE);
    end

endmodule

// File: rtl/id_ex_stage.sv
// MIPS decode stage with ID/EX pipeline register and load-use stall insertion.
// Optional macro ID_WB_BYPASS_EN forwards the write-back port into the operand read.
import mips_pkg::*;

module id_ex_stage #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [XLEN-1:0]        if_instr,
    input  logic [XLEN-1:0]        if_pc,
    output logic                   id_ready,
    input  logic                   flush,
    output logic [REG_IDX_W-1:0]   rd1_index,
    output logic [REG_IDX_W-1:0]   rd2_index,
    input  logic [XLEN-1:0]        rd1_out,
    input  logic [XLEN-1:0]        rd2_out,
    input  logic                   wb_regWrite,
    input  logic [REG_IDX_W-1:0]   wb_index,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   ex_valid,
    output logic [OPC_W-1:0]       ex_op,
    output logic [FN_W-1:0]        ex_funct,
    output logic [XLEN-1:0]        ex_rs_val,
    output logic [XLEN-1:0]        ex_rt_val,
    output logic [XLEN-1:0]        ex_imm,
    output logic [REG_IDX_W-1:0]   ex_dst,
    output logic                   ex_regWrite,
    output logic                   ex_memRead,
    output logic [XLEN-1:0]        ex_pc,
    output logic [STALL_CNT_W-1:0] stall_count
);

    id_state_e             r_state;
    id_state_e             w_state_nxt;
    logic                  w_bubble;
    logic                  w_issue;
    logic                  w_hazard;
    dec_t                  w_dec;
    logic [REG_IDX_W-1:0]  w_rs;
    logic [REG_IDX_W-1:0]  w_rt;
    logic [XLEN-1:0]       w_rs_raw;
    logic [XLEN-1:0]       w_rt_raw;
    logic [XLEN-1:0]       w_rs_val;
    logic [XLEN-1:0]       w_rt_val;

    logic                   r_valid;
    logic [OPC_W-1:0]       r_op;
    logic [FN_W-1:0]        r_funct;
    logic [XLEN-1:0]        r_rs_val;
    logic [XLEN-1:0]        r_rt_val;
    logic [XLEN-1:0]        r_imm;
    logic [REG_IDX_W-1:0]   r_dst;
    logic                   r_reg_write;
    logic                   r_mem_read;
    logic [XLEN-1:0]        r_pc;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_rs      = if_instr[25:21];
    assign w_rt      = if_instr[20:16];
    assign rd1_index = w_rs;
    assign rd2_index = w_rt;

    id_decoder u_dec (
        .i_instr (if_instr),
        .o_dec   (w_dec)
    );

`ifdef ID_WB_BYPASS_EN
    // Same-cycle write-back wins over the (read-before-write) register file.
    assign w_rs_raw = (wb_regWrite && (wb_index != '0) && (wb_index == w_rs)) ? wb_data : rd1_out;
    assign w_rt_raw = (wb_regWrite && (wb_index != '0) && (wb_index == w_rt)) ? wb_data : rd2_out;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_regWrite, wb_index, wb_data};
    assign w_rs_raw    = rd1_out;
    assign w_rt_raw    = rd2_out;
`endif

    assign w_rs_val = (w_rs == '0) ? '0 : w_rs_raw;
    assign w_rt_val = (w_rt == '0) ? '0 : w_rt_raw;

    assign w_hazard = if_valid && r_valid && r_mem_read && (r_dst != '0)
                   && ((r_dst == w_rs) || (w_dec.uses_rt && (r_dst == w_rt)));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; a flush always returns to RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_hazard) w_state_nxt = ST_STALL;
            ST_STALL: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
        if (flush) begin
            w_state_nxt = ST_RUN;
        end
    end

    // FSM outputs; a squashed instruction never holds IF
    always_comb begin
        w_bubble = 1'b0;
        case (r_state)
            ST_RUN:   w_bubble = w_hazard && !flush;
            ST_STALL: w_bubble = 1'b0;
            default:  w_bubble = 1'b0;
        endcase
        id_ready = !w_bubble;
        w_issue  = if_valid && !w_bubble && !flush;
    end

    // ID/EX register: fields latch every cycle, only the qualifiers are gated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_op        <= '0;
            r_funct     <= '0;
            r_rs_val    <= '0;
            r_rt_val    <= '0;
            r_imm       <= '0;
            r_dst       <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_pc        <= '0;
        end else begin
            r_valid     <= w_issue;
            r_op        <= if_instr[31:26];
            r_funct     <= if_instr[5:0];
            r_rs_val    <= w_rs_val;
            r_rt_val    <= w_rt_val;
            r_imm       <= w_dec.imm;
            r_dst       <= w_dec.dst;
            r_reg_write <= w_issue && w_dec.reg_write;
            r_mem_read  <= w_issue && w_dec.mem_read;
            r_pc        <= if_pc;
        end
    end

    // Saturating bubble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_bubble && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign ex_valid    = r_valid;
    assign ex_op       = r_op;
    assign ex_funct    = r_funct;
    assign ex_rs_val   = r_rs_val;
    assign ex_rt_val   = r_rt_val;
    assign ex_imm      = r_imm;
    assign ex_dst      = r_dst;
    assign ex_regWrite = r_reg_write;
    assign ex_memRead  = r_mem_read;
    assign ex_pc       = r_pc;
    assign stall_count = r_stall_cnt;

endmodule
